// File: rtl/cam_pkg.sv
// cam_pkg: camera power sequencing states and default timing constants,
// shared by the power sequencer and the SCCB register loader.
package cam_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        LOCK_STABLE,
        PWDN_HOLD,
        RST_HOLD,
        SETTLE,
        DONE
    } state_t;

    localparam int unsigned DEF_LOCK_CYCLES = 1024;
    localparam int unsigned DEF_T_PWDN      = 240;
    localparam int unsigned DEF_T_RST       = 24000;
    localparam int unsigned DEF_T_SETTLE    = 24000;
    localparam int          TIMER_W         = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cam_power_seq.sv
// cam_power_seq: camera power-up sequencer gated on a stable PLL lock,
// with lock-loss recovery and a saturating lock-loss counter.
module cam_power_seq
    import cam_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int unsigned T_PWDN      = DEF_T_PWDN,
    parameter int unsigned T_RST       = DEF_T_RST,
    parameter int unsigned T_SETTLE    = DEF_T_SETTLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       cam_pwdn,
    output logic       cam_reset_n,
    output logic       xclk_en,
    output logic       cfg_start,
    output logic       ready,
    output logic [3:0] lock_loss_cnt
);

    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PWDN_LAST   = TIMER_W'(T_PWDN - 1);
    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(T_RST - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(T_SETTLE - 1);

    logic               lock_s;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         loss_q, loss_d;
    logic               pwdn_q, pwdn_d;
    logic               reset_n_q, reset_n_d;
    logic               xclk_q, xclk_d;
    logic               cfg_q, cfg_d;
    logic               ready_q, ready_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK:   if (lock_s) state_d = LOCK_STABLE;
            LOCK_STABLE: state_d = !lock_s ? WAIT_LOCK : (timer_q == LOCK_LAST ? PWDN_HOLD : LOCK_STABLE);
            PWDN_HOLD:   if (timer_q == PWDN_LAST) state_d = RST_HOLD;
            RST_HOLD:    if (timer_q == RST_LAST) state_d = SETTLE;
            SETTLE:      if (timer_q == SETTLE_LAST) state_d = DONE;
            DONE:        state_d = DONE;
            default:     state_d = WAIT_LOCK;
        endcase
        // Lock loss once the camera is being powered overrides any timer expiry
        if (!lock_s && state_q inside {PWDN_HOLD, RST_HOLD, SETTLE, DONE}) begin
            state_d = WAIT_LOCK;
            loss_d  = (loss_q == 4'd15) ? loss_q : loss_q + 4'd1;
        end
        timer_d   = (state_d != state_q) ? '0 : timer_q + 1'b1;
        pwdn_d    = state_d inside {WAIT_LOCK, LOCK_STABLE, PWDN_HOLD};
        reset_n_d = state_d inside {SETTLE, DONE};
        xclk_d    = state_d inside {PWDN_HOLD, RST_HOLD, SETTLE, DONE};
        ready_d   = state_d == DONE;
        cfg_d     = state_d == DONE && state_q != DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            timer_q   <= '0;
            loss_q    <= '0;
            pwdn_q    <= 1'b1;
            reset_n_q <= 1'b0;
            xclk_q    <= 1'b0;
            cfg_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            loss_q    <= loss_d;
            pwdn_q    <= pwdn_d;
            reset_n_q <= reset_n_d;
            xclk_q    <= xclk_d;
            cfg_q     <= cfg_d;
            ready_q   <= ready_d;
        end
    end

    assign cam_pwdn      = pwdn_q;
    assign cam_reset_n   = reset_n_q;
    assign xclk_en       = xclk_q;
    assign cfg_start     = cfg_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_cam_power_seq.sv
// tb_cam_power_seq: directed and randomized lock stimulus against an
// elapsed-time reference model of the camera power-up sequence.
module tb_cam_power_seq;

    localparam int LC = 4;
    localparam int TP = 3;
    localparam int TR = 5;
    localparam int TS = 6;
    localparam int E_PWDN_END = LC + TP;
    localparam int E_RST_END  = LC + TP + TR;
    localparam int E_DONE     = LC + TP + TR + TS;
    localparam int LATENCY    = 3 + E_DONE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       cam_pwdn;
    logic       cam_reset_n;
    logic       xclk_en;
    logic       cfg_start;
    logic       ready;
    logic [3:0] lock_loss_cnt;

    int errors = 0;
    int checks = 0;

    // Model: m_e is cycles elapsed since the synchronized lock was seen (-1 = none)
    int   m_e;
    int   m_loss;
    logic m_l1, m_l2;

    cam_power_seq #(
        .LOCK_CYCLES (LC),
        .T_PWDN      (TP),
        .T_RST       (TR),
        .T_SETTLE    (TS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .cam_pwdn      (cam_pwdn),
        .cam_reset_n   (cam_reset_n),
        .xclk_en       (xclk_en),
        .cfg_start     (cfg_start),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cfg(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_start && n < 100);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e    <= -1;
            m_loss <= 0;
            m_l1   <= 1'b0;
            m_l2   <= 1'b0;
        end else begin
            m_l1 <= pll_locked;
            m_l2 <= m_l1;
            if (m_e < 0)
                m_e <= m_l2 ? 0 : -1;
            else if (!m_l2) begin
                m_e <= -1;
                if (m_e >= LC && m_loss < 15) m_loss <= m_loss + 1;
            end else if (m_e <= E_DONE)
                m_e <= m_e + 1;
        end
    end

    always @(negedge clk) begin
        chk("pwdn",    cam_pwdn,      m_e < E_PWDN_END);
        chk("reset_n", cam_reset_n,   m_e >= E_RST_END);
        chk("xclk",    xclk_en,       m_e >= LC);
        chk("ready",   ready,         m_e >= E_DONE);
        chk("cfg",     cfg_start,     m_e == E_DONE);
        chk("loss",    lock_loss_cnt, m_loss);
    end

    initial begin
        int n;
        logic seen;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pwdn",    cam_pwdn, 1);
        chk("rst_reset_n", cam_reset_n, 0);
        chk("rst_xclk",    xclk_en, 0);
        chk("rst_cfg",     cfg_start, 0);
        chk("rst_ready",   ready, 0);
        chk("rst_loss",    lock_loss_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pll_locked = 1'b1;
        wait_cfg(n);
        chk("first_cfg_latency", n, LATENCY);
        @(negedge clk);
        chk("cfg_single_pulse", cfg_start, 0);
        chk("ready_held", ready, 1);

        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_ready", ready, 0);
        chk("drop_xclk", xclk_en, 0);
        chk("drop_pwdn", cam_pwdn, 1);
        chk("drop_reset_n", cam_reset_n, 0);
        chk("drop_loss", lock_loss_cnt, 1);
        pll_locked = 1'b1;
        wait_cfg(n);
        chk("relock_cfg_latency", n, LATENCY);

        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        wait_cfg(n);
        chk("glitch_recount_latency", n, LATENCY);
        chk("glitch_no_loss", lock_loss_cnt, 2);

        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (E_DONE) @(negedge clk);
        pll_locked = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= ready | cfg_start;
        end
        chk("settle_expiry_drop_no_ready", seen, 0);
        chk("settle_expiry_drop_loss", lock_loss_cnt, 4);

        repeat (17) begin
            pll_locked = 1'b1;
            wait_cfg(n);
            pll_locked = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("loss_saturated", lock_loss_cnt, 15);

        pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        chk("in_rst_hold", {cam_pwdn, cam_reset_n, xclk_en}, 3'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwdn",    cam_pwdn, 1);
        chk("async_reset_n", cam_reset_n, 0);
        chk("async_xclk",    xclk_en, 0);
        chk("async_cfg",     cfg_start, 0);
        chk("async_ready",   ready, 0);
        chk("async_loss",    lock_loss_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cfg(n);
        chk("post_reset_cfg_latency", n, LATENCY);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < (pll_locked ? 2 : 8)) pll_locked = ~pll_locked;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
